// File: rtl/drac_pkg.sv
// Shared PCR command encoding, FSM states and address map.
// Used by pcr_counter_bank and its counter slices.
package drac_pkg;

  typedef enum logic [2:0] {
    PCR_NOP   = 3'd0,
    PCR_READ  = 3'd1,
    PCR_WRITE = 3'd2,
    PCR_SET   = 3'd3,
    PCR_CLEAR = 3'd4
  } pcr_cmd_t;

  typedef enum logic [1:0] {
    PCR_IDLE   = 2'd0,
    PCR_ACCESS = 2'd1,
    PCR_RESP   = 2'd2
  } pcr_state_t;

  localparam logic [11:0] PCR_CNT_BASE = 12'hB03;
  localparam logic [11:0] PCR_INHIBIT  = 12'h320;
  localparam logic [11:0] PCR_OVF      = 12'hDA0;

endpackage

// File: rtl/pcr_counter.sv
// One 64-bit event counter; a write beats a same-cycle increment.
// wrap_o flags an increment that rolls all-ones over to zero.
module pcr_counter
  import drac_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        inc_i,
  input  logic        inhibit_i,
  input  logic        we_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] cnt_o,
  output logic        wrap_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;
  logic        inc_en;

  assign inc_en = inc_i && !inhibit_i;

  // next value: write first, else gated increment
  always_comb begin
    cnt_d = cnt_q;
    if (we_i) begin
      cnt_d = wdata_i;
    end else if (inc_en) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // counter register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = !we_i && inc_en && (&cnt_q);

endmodule

// File: rtl/pcr_counter_bank.sv
// PCR slave: request FSM, address decode, inhibit mask and counters.
// Optional PCR_OVF_IRQ_EN adds sticky overflow flags and ovf_irq_o.
module pcr_counter_bank
  import drac_pkg::*;
#(
  parameter int   NUM_CNT = 8,
  parameter logic CORE_ID = 1'b0
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               pcr_req_valid_i,
  output logic               pcr_req_ready_o,
  input  logic [11:0]        pcr_req_addr_i,
  input  logic [63:0]        pcr_req_data_i,
  input  logic [2:0]         pcr_req_we_i,
  input  logic               pcr_req_core_id_i,
  output logic               pcr_resp_valid_o,
  output logic [63:0]        pcr_resp_data_o,
  output logic               pcr_resp_core_id_o,
  input  logic [NUM_CNT-1:0] event_i,
  output logic               ovf_irq_o
);

  pcr_state_t state_q;
  pcr_state_t state_d;

  logic [11:0] addr_q;
  logic [63:0] data_q;
  logic [2:0]  cmd_q;
  logic        id_q;
  logic        accept;

  logic [NUM_CNT-1:0] inhibit_q;
  logic [63:0]        resp_data_q;
  logic               resp_id_q;

  logic [63:0] cnt [NUM_CNT];
  logic [NUM_CNT-1:0] wrap;
  logic [NUM_CNT-1:0] cnt_we;

  logic [11:0] cnt_off;
  logic        cnt_hit;
  logic        id_ok;
  logic        acc;
  logic        wr_en;
  logic        do_wr;
  logic [63:0] rd_val;
  logic [63:0] new_val;

  assign cnt_off = addr_q - PCR_CNT_BASE;
  assign cnt_hit = (addr_q >= PCR_CNT_BASE) &&
                   (cnt_off < 12'(NUM_CNT));
  assign id_ok   = (id_q == CORE_ID);
  assign acc     = (state_q == PCR_ACCESS) && id_ok;
  assign do_wr   = acc && wr_en;

`ifdef PCR_OVF_IRQ_EN
  logic [NUM_CNT-1:0] ovf_q;
  logic [NUM_CNT-1:0] ovf_clr;

  assign ovf_clr = (acc && cmd_q == PCR_CLEAR &&
                    addr_q == PCR_OVF) ?
                   data_q[NUM_CNT-1:0] : '0;

  // sticky flags; a wrap in the clearing cycle survives
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr) | wrap;
    end
  end

  assign ovf_irq_o = |ovf_q;
`else
  logic unused_wrap;
  assign unused_wrap = ^wrap;
  assign ovf_irq_o   = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= PCR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d          = state_q;
    pcr_req_ready_o  = 1'b0;
    pcr_resp_valid_o = 1'b0;
    accept           = 1'b0;
    unique case (state_q)
      PCR_IDLE: begin
        pcr_req_ready_o = 1'b1;
        if (pcr_req_valid_i) begin
          accept  = 1'b1;
          state_d = PCR_ACCESS;
        end
      end
      PCR_ACCESS: begin
        state_d = PCR_RESP;
      end
      PCR_RESP: begin
        pcr_resp_valid_o = (cmd_q != PCR_NOP);
        state_d          = PCR_IDLE;
      end
      default: begin
        state_d = PCR_IDLE;
      end
    endcase
  end

  // request latch on accept
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q <= '0;
      data_q <= '0;
      cmd_q  <= PCR_NOP;
      id_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= pcr_req_addr_i;
      data_q <= pcr_req_data_i;
      cmd_q  <= pcr_req_we_i;
      id_q   <= pcr_req_core_id_i;
    end
  end

  // old-value read mux over counters, inhibit and flags
  always_comb begin
    rd_val = '0;
    if (cnt_hit) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (cnt_off == 12'(i)) begin
          rd_val = cnt[i];
        end
      end
    end
    if (addr_q == PCR_INHIBIT) begin
      rd_val = 64'(inhibit_q);
    end
`ifdef PCR_OVF_IRQ_EN
    if (addr_q == PCR_OVF) begin
      rd_val = 64'(ovf_q);
    end
`endif
  end

  // modified value for write-class commands
  always_comb begin
    new_val = rd_val;
    wr_en   = 1'b0;
    case (cmd_q)
      PCR_WRITE: begin
        new_val = data_q;
        wr_en   = 1'b1;
      end
      PCR_SET: begin
        new_val = rd_val | data_q;
        wr_en   = 1'b1;
      end
      PCR_CLEAR: begin
        new_val = rd_val & ~data_q;
        wr_en   = 1'b1;
      end
      default: begin
        new_val = rd_val;
      end
    endcase
  end

  // inhibit mask and response capture
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inhibit_q   <= '0;
      resp_data_q <= '0;
      resp_id_q   <= 1'b0;
    end else begin
      if (do_wr && addr_q == PCR_INHIBIT) begin
        inhibit_q <= new_val[NUM_CNT-1:0];
      end
      if (state_q == PCR_ACCESS) begin
        resp_data_q <= id_ok ? rd_val : '0;
        resp_id_q   <= id_q;
      end
    end
  end

  assign pcr_resp_data_o    = resp_data_q;
  assign pcr_resp_core_id_o = resp_id_q;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    assign cnt_we[g] = do_wr && cnt_hit &&
                       (cnt_off == 12'(g));
    pcr_counter u_cnt (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .inc_i     (event_i[g]),
      .inhibit_i (inhibit_q[g]),
      .we_i      (cnt_we[g]),
      .wdata_i   (new_val),
      .cnt_o     (cnt[g]),
      .wrap_o    (wrap[g])
    );
  end

endmodule

// File: tb/tb_pcr_counter_bank.sv
// Directed bench for pcr_counter_bank.
// Checks timing, commands, map, inhibit, wrap and reset abort.
module tb_pcr_counter_bank;

  logic        clk_i;
  logic        rstn_i;
  logic        pcr_req_valid_i;
  logic        pcr_req_ready_o;
  logic [11:0] pcr_req_addr_i;
  logic [63:0] pcr_req_data_i;
  logic [2:0]  pcr_req_we_i;
  logic        pcr_req_core_id_i;
  logic        pcr_resp_valid_o;
  logic [63:0] pcr_resp_data_o;
  logic        pcr_resp_core_id_o;
  logic [7:0]  event_i;
  logic        ovf_irq_o;

  int n_chk;
  int n_err;

  pcr_counter_bank #(.NUM_CNT(8), .CORE_ID(1'b0)) dut (
    .clk_i              (clk_i),
    .rstn_i             (rstn_i),
    .pcr_req_valid_i    (pcr_req_valid_i),
    .pcr_req_ready_o    (pcr_req_ready_o),
    .pcr_req_addr_i     (pcr_req_addr_i),
    .pcr_req_data_i     (pcr_req_data_i),
    .pcr_req_we_i       (pcr_req_we_i),
    .pcr_req_core_id_i  (pcr_req_core_id_i),
    .pcr_resp_valid_o   (pcr_resp_valid_o),
    .pcr_resp_data_o    (pcr_resp_data_o),
    .pcr_resp_core_id_o (pcr_resp_core_id_o),
    .event_i            (event_i),
    .ovf_irq_o          (ovf_irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One full transaction; ev is driven during ACCESS.
  task automatic req(input string tag,
                     input logic [2:0] cmd,
                     input logic [11:0] addr,
                     input logic [63:0] data,
                     input logic id,
                     input logic [7:0] ev,
                     input logic [63:0] exp);
    @(negedge clk_i);
    pcr_req_valid_i   = 1'b1;
    pcr_req_we_i      = cmd;
    pcr_req_addr_i    = addr;
    pcr_req_data_i    = data;
    pcr_req_core_id_i = id;
    chk({tag, " ready_idle"}, 64'(pcr_req_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    pcr_req_valid_i = 1'b0;
    event_i         = ev;
    chk({tag, " ready_acc"}, 64'(pcr_req_ready_o), 64'd0);
    chk({tag, " rv_acc"}, 64'(pcr_resp_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    event_i = '0;
    chk({tag, " rv_resp"}, 64'(pcr_resp_valid_o),
        64'(cmd != 3'd0));
    chk({tag, " ready_resp"}, 64'(pcr_req_ready_o), 64'd0);
    if (cmd != 3'd0) begin
      chk({tag, " data"}, pcr_resp_data_o, exp);
      chk({tag, " id"}, 64'(pcr_resp_core_id_o), 64'(id));
    end
    @(posedge clk_i);
    #1;
    chk({tag, " rv_done"}, 64'(pcr_resp_valid_o), 64'd0);
    chk({tag, " ready_done"}, 64'(pcr_req_ready_o), 64'd1);
  endtask

  // n consecutive cycles of event mask m
  task automatic pulse(input logic [7:0] m, input int n);
    @(negedge clk_i);
    event_i = m;
    repeat (n) @(negedge clk_i);
    event_i = '0;
  endtask

  initial begin
    n_chk             = 0;
    n_err             = 0;
    rstn_i            = 1'b0;
    pcr_req_valid_i   = 1'b0;
    pcr_req_addr_i    = '0;
    pcr_req_data_i    = '0;
    pcr_req_we_i      = '0;
    pcr_req_core_id_i = 1'b0;
    event_i           = '0;
    repeat (2) @(negedge clk_i);
    chk("rst ready", 64'(pcr_req_ready_o), 64'd1);
    chk("rst rv", 64'(pcr_resp_valid_o), 64'd0);
    chk("rst data", pcr_resp_data_o, 64'd0);
    chk("rst id", 64'(pcr_resp_core_id_o), 64'd0);
    chk("rst irq", 64'(ovf_irq_o), 64'd0);
    rstn_i = 1'b1;

    // 1: basic read timing
    req("t1 rd", 3'd1, 12'hB03, 64'd0, 1'b0, 8'h00, 64'd0);

    // 2: write then count
    req("t2 wr", 3'd2, 12'hB04, 64'd5, 1'b0, 8'h00, 64'd0);
    pulse(8'h02, 3);
    req("t2 rd", 3'd1, 12'hB04, 64'd0, 1'b0, 8'h00, 64'd8);

    // 3: wrap-around
    req("t3 wr", 3'd2, 12'hB03, '1, 1'b0, 8'h00, 64'd0);
    pulse(8'h01, 1);
    req("t3 rd", 3'd1, 12'hB03, 64'd0, 1'b0, 8'h00, 64'd0);
`ifdef PCR_OVF_IRQ_EN
    chk("t3 irq_set", 64'(ovf_irq_o), 64'd1);
    req("t3 clr", 3'd4, 12'hDA0, 64'd1, 1'b0, 8'h00, 64'd1);
    chk("t3 irq_clr", 64'(ovf_irq_o), 64'd0);
`else
    chk("t3 irq_off", 64'(ovf_irq_o), 64'd0);
    req("t3 ovf", 3'd1, 12'hDA0, 64'd0, 1'b0, 8'h00, 64'd0);
`endif

    // 4: inhibit
    req("t4 set", 3'd3, 12'h320, 64'd1, 1'b0, 8'h00, 64'd0);
    pulse(8'h01, 10);
    req("t4 rd0", 3'd1, 12'hB03, 64'd0, 1'b0, 8'h00, 64'd0);
    req("t4 rdi", 3'd1, 12'h320, 64'd0, 1'b0, 8'h00, 64'd1);
    req("t4 clr", 3'd4, 12'h320, 64'd1, 1'b0, 8'h00, 64'd1);
    pulse(8'h01, 2);
    req("t4 rd1", 3'd1, 12'hB03, 64'd0, 1'b0, 8'h00, 64'd2);
    req("t4 hi", 3'd2, 12'h320, '1, 1'b0, 8'h00, 64'd0);
    req("t4 rdh", 3'd1, 12'h320, 64'd0, 1'b0, 8'h00, 64'hFF);
    req("t4 zero", 3'd2, 12'h320, 64'd0, 1'b0, 8'h00, 64'hFF);

    // 5: write beats event, unmapped, id mismatch
    req("t5 wr", 3'd2, 12'hB03, 64'd7, 1'b0, 8'h01, 64'd2);
    req("t5 rd", 3'd1, 12'hB03, 64'd0, 1'b0, 8'h00, 64'd7);
    req("t5 unm", 3'd1, 12'h7FF, 64'd0, 1'b0, 8'h00, 64'd0);
    req("t5 uwr", 3'd2, 12'hB0B, 64'd9, 1'b0, 8'h00, 64'd0);
    req("t5 id1r", 3'd1, 12'hB04, 64'd0, 1'b1, 8'h00, 64'd0);
    req("t5 id1w", 3'd2, 12'hB04, 64'd99, 1'b1, 8'h00, 64'd0);
    req("t5 keep", 3'd1, 12'hB04, 64'd0, 1'b0, 8'h00, 64'd8);
    req("t5 set", 3'd3, 12'hB04, 64'h10, 1'b0, 8'h00, 64'd8);
    req("t5 clr", 3'd4, 12'hB04, 64'h08, 1'b0, 8'h00, 64'h18);
    req("t5 c6", 3'd6, 12'hB04, 64'hFF, 1'b0, 8'h00, 64'h10);
    req("t5 nop", 3'd0, 12'hB04, 64'h1, 1'b0, 8'h00, 64'd0);
    req("t5 rd7", 3'd1, 12'hB0A, 64'd0, 1'b0, 8'h00, 64'd0);
    req("t5 fin", 3'd1, 12'hB04, 64'd0, 1'b0, 8'h00, 64'h10);

    // 6: reset during ACCESS aborts
    @(negedge clk_i);
    pcr_req_valid_i = 1'b1;
    pcr_req_we_i    = 3'd2;
    pcr_req_addr_i  = 12'hB03;
    pcr_req_data_i  = 64'h55;
    @(posedge clk_i);
    #1;
    pcr_req_valid_i = 1'b0;
    rstn_i          = 1'b0;
    @(negedge clk_i);
    chk("t6 rst rv", 64'(pcr_resp_valid_o), 64'd0);
    chk("t6 rst ready", 64'(pcr_req_ready_o), 64'd1);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      chk("t6 no_resp", 64'(pcr_resp_valid_o), 64'd0);
      chk("t6 ready", 64'(pcr_req_ready_o), 64'd1);
    end
    req("t6 rd0", 3'd1, 12'hB03, 64'd0, 1'b0, 8'h00, 64'd0);
    req("t6 rd1", 3'd1, 12'hB04, 64'd0, 1'b0, 8'h00, 64'd0);
    req("t6 rd7", 3'd1, 12'hB0A, 64'd0, 1'b0, 8'h00, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
